// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for the UART receiver datapath.
// Arms the receiver one frame at a time and latches the parity setting per frame.
// Completed bytes are pushed into a small first-word-fall-through FIFO.
// Receive errors are condensed into sticky flags and one registered interrupt line.
// Optional build macro: UART_RX_CTRL_TIMEOUT_EN adds a per-frame rx_busy watchdog.
module uart_rx_ctrl #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ctrl_en,
  input  logic                          cfg_parity_en,
  output logic                          rx_start,
  output logic                          rx_parity_en,
  input  logic                          rx_busy,
  input  logic                          rx_done,
  input  logic                          rx_err,
  input  logic                          rx_parity_err,
  input  logic [DATA_W-1:0]             rx_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          timeout,
  input  logic                          err_clr,
  output logic                          irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StArm, StReceive, StStore} state_e;

  state_e            state_q, state_d;
  logic              par_en_q, par_en_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              ev_err_q, ev_err_d;
  logic              ev_par_q, ev_par_d;
  logic              ev_to_q, ev_to_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic frame_err_q, frame_err_d;
  logic parity_err_q, parity_err_d;
  logic overrun_q, overrun_d;
  logic irq_q, irq_d;

  logic wd_trip;
  logic store_ok, push, pop, drop;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;

  // Watchdog counts busy cycles in RECEIVE; cleared whenever outside RECEIVE.
  always_comb begin
    wd_d = wd_q;
    if (state_q != StReceive) begin
      wd_d = '0;
    end else if (rx_busy) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // A real completion in the same cycle takes precedence over the watchdog.
  assign wd_trip = (state_q == StReceive) && rx_busy && !rx_done && !rx_err &&
                   (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag; setting wins over clearing.
  always_comb begin
    timeout_d = wd_trip | (timeout_q & ~err_clr);
  end

  // Watchdog and timeout flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_busy;

  assign unused_busy = rx_busy;
  assign wd_trip     = 1'b0;
  assign timeout     = 1'b0;
`endif

  // FSM next state plus per-frame capture of the receiver result.
  always_comb begin
    state_d  = state_q;
    par_en_d = par_en_q;
    byte_d   = byte_q;
    ev_err_d = ev_err_q;
    ev_par_d = ev_par_q;
    ev_to_d  = ev_to_q;
    case (state_q)
      StIdle: begin
        if (ctrl_en) state_d = StArm;
      end
      StArm: begin
        state_d = StReceive;
      end
      StReceive: begin
        if (rx_done || rx_err) begin
          state_d  = StStore;
          byte_d   = rx_data;
          ev_err_d = rx_err;
          ev_par_d = rx_parity_err & ~rx_err;
          ev_to_d  = 1'b0;
        end else if (wd_trip) begin
          state_d  = StStore;
          ev_err_d = 1'b0;
          ev_par_d = 1'b0;
          ev_to_d  = 1'b1;
        end
      end
      StStore: begin
        state_d = ctrl_en ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Parity setting is taken on entry to ARM so it is stable for the whole frame.
    if (state_d == StArm) par_en_d = cfg_parity_en;
  end

  assign store_ok = (state_q == StStore) && !ev_err_q && !ev_to_q;
  assign pop      = rd_en && !fifo_empty;
  assign push     = store_ok && (!fifo_full || pop);
  assign drop     = store_ok && fifo_full && !pop;

  // FIFO pointer/occupancy update and sticky error flags.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q + CntW'(push) - CntW'(pop);
    frame_err_d  = ((state_q == StStore) && ev_err_q) | (frame_err_q & ~err_clr);
    parity_err_d = (store_ok && ev_par_q) | (parity_err_q & ~err_clr);
    overrun_d    = drop | (overrun_q & ~err_clr);
    irq_d        = !fifo_empty | frame_err_q | parity_err_q | overrun_q | timeout;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      par_en_q     <= 1'b0;
      byte_q       <= '0;
      ev_err_q     <= 1'b0;
      ev_par_q     <= 1'b0;
      ev_to_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_en_q     <= par_en_d;
      byte_q       <= byte_d;
      ev_err_q     <= ev_err_d;
      ev_par_q     <= ev_par_d;
      ev_to_q      <= ev_to_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      irq_q        <= irq_d;
    end
  end

  // FIFO storage; flushed logically by the pointer/count reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= byte_q;
  end

  assign rx_start     = (state_q == StArm);
  assign rx_parity_en = par_en_q;
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_count   = count_q;
  assign rd_data      = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign frame_err    = frame_err_q;
  assign parity_err   = parity_err_q;
  assign overrun      = overrun_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; the receiver is emulated by driving its status pins.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst, ctrl_en, cfg_parity_en;
  logic       rx_start, rx_parity_en;
  logic       rx_busy, rx_done, rx_err, rx_parity_err;
  logic [7:0] rx_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       fifo_empty, fifo_full;
  logic [2:0] fifo_count;
  logic       frame_err, parity_err, overrun, timeout;
  logic       err_clr, irq;

  int vectors = 0;
  int errors  = 0;
  int starts  = 0;
  int s0;

  uart_rx_ctrl #(
    .DATA_W         (8),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (512)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_en       (ctrl_en),
    .cfg_parity_en (cfg_parity_en),
    .rx_start      (rx_start),
    .rx_parity_en  (rx_parity_en),
    .rx_busy       (rx_busy),
    .rx_done       (rx_done),
    .rx_err        (rx_err),
    .rx_parity_err (rx_parity_err),
    .rx_data       (rx_data),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_count    (fifo_count),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .overrun       (overrun),
    .timeout       (timeout),
    .err_clr       (err_clr),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Count arm pulses, one per cycle in which rx_start is high.
  always @(posedge clk) if (rx_start === 1'b1) starts++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Emulated frame: from ARM or RECEIVE, 160 busy cycles, then a status pulse.
  // Returns with the DUT in STORE.
  task automatic send(input logic [7:0] d, input logic done, input logic err, input logic perr);
    if (rx_start) tick();
    rx_busy = 1'b1;
    repeat (160) tick();
    rx_busy       = 1'b0;
    rx_done       = done;
    rx_err        = err;
    rx_parity_err = perr;
    rx_data       = d;
    tick();
    rx_done       = 1'b0;
    rx_err        = 1'b0;
    rx_parity_err = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctrl_en = 1'b0; cfg_parity_en = 1'b0;
    rx_busy = 1'b0; rx_done = 1'b0; rx_err = 1'b0; rx_parity_err = 1'b0; rx_data = 8'h00;
    rd_en = 1'b0; err_clr = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rx_start", rx_start, 0);
    chk("rst_par_en", rx_parity_en, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_flags", {frame_err, parity_err, overrun, timeout}, 0);
    chk("rst_irq", irq, 0);
    tick();
    chk("idle_no_start", rx_start, 0);

    // Good frame 0x55 with parity enabled
    cfg_parity_en = 1'b1;
    ctrl_en       = 1'b1;
    s0            = starts;
    tick();
    chk("arm_start", rx_start, 1);
    chk("arm_par_en", rx_parity_en, 1);
    send(8'h55, 1'b1, 1'b0, 1'b0);
    chk("store_empty", fifo_empty, 1);
    chk("store_no_start", rx_start, 0);
    tick();
    chk("n2_empty", fifo_empty, 0);
    chk("n2_rd_data", rd_data, 8'h55);
    chk("n2_count", fifo_count, 1);
    chk("n2_rearm", rx_start, 1);
    chk("n2_irq", irq, 0);
    tick();
    chk("n3_irq", irq, 1);
    chk("n3_flags", {frame_err, parity_err, overrun, timeout}, 0);
    chk("n3_starts", starts - s0, 2);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pop_count", fifo_count, 0);
    chk("pop_empty", fifo_empty, 1);
    chk("pop_irq_lag", irq, 1);
    tick();
    chk("pop_irq_low", irq, 0);

    // Parity error frame: stored anyway, flag clearable, irq held by FIFO
    send(8'h55, 1'b1, 1'b0, 1'b1);
    tick();
    chk("perr_flag", parity_err, 1);
    chk("perr_data", rd_data, 8'h55);
    chk("perr_count", fifo_count, 1);
    pulse_clr();
    chk("perr_clr", parity_err, 0);
    chk("perr_irq", irq, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("perr_pop_irq", irq, 1);
    tick();
    chk("perr_irq_low", irq, 0);

    // Set beats clear in the same cycle
    send(8'h66, 1'b1, 1'b0, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("set_over_clr", parity_err, 1);
    pulse_clr();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;

    // Five frames, no reads: overrun, 0x05 lost
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
    tick();
    chk("ovr_count", fifo_count, 4);
    chk("ovr_full", fifo_full, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_other", {frame_err, parity_err}, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_pop_data", rd_data, i);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("ovr_drained", fifo_empty, 1);
    pulse_clr();
    chk("ovr_clr", overrun, 0);

    // Five frames with a pop in the fifth STORE cycle: no overrun
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pp_overrun", overrun, 0);
    chk("pp_count", fifo_count, 4);
    chk("pp_full", fifo_full, 1);
    for (int i = 2; i <= 5; i++) begin
      chk("pp_pop_data", rd_data, i);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("pp_drained", fifo_count, 0);

    // Framing error: nothing stored, re-arm two cycles after rx_err
    send(8'hAA, 1'b0, 1'b1, 1'b0);
    chk("ferr_store_no_start", rx_start, 0);
    tick();
    chk("ferr_flag", frame_err, 1);
    chk("ferr_empty", fifo_empty, 1);
    chk("ferr_rearm", rx_start, 1);
    pulse_clr();

    // rx_err and rx_done together: error wins
    send(8'h33, 1'b1, 1'b1, 1'b0);
    tick();
    chk("both_flag", frame_err, 1);
    chk("both_empty", fifo_empty, 1);
    pulse_clr();

    // ctrl_en and cfg_parity_en dropped mid-frame
    rx_busy = 1'b1;
    repeat (80) tick();
    ctrl_en       = 1'b0;
    cfg_parity_en = 1'b0;
    repeat (80) tick();
    chk("mid_par_hold", rx_parity_en, 1);
    rx_busy = 1'b0;
    rx_done = 1'b1;
    rx_data = 8'h77;
    tick();
    rx_done = 1'b0;
    tick();
    chk("drop_count", fifo_count, 1);
    chk("drop_data", rd_data, 8'h77);
    chk("drop_no_start", rx_start, 0);
    s0 = starts;
    repeat (20) tick();
    chk("drop_no_rearm", starts - s0, 0);
    chk("drop_par_hold", rx_parity_en, 1);
    ctrl_en = 1'b1;
    tick();
    chk("rearm_start", rx_start, 1);
    chk("rearm_par_new", rx_parity_en, 0);

    // Pop to empty, then rd_en on empty is ignored
    rd_en = 1'b1;
    tick();
    chk("last_pop", fifo_count, 0);
    tick();
    rd_en = 1'b0;
    chk("underflow_count", fifo_count, 0);
    chk("underflow_empty", fifo_empty, 1);

    // Reset mid-frame flushes everything; late rx_done is ignored
    send(8'h99, 1'b1, 1'b0, 1'b1);
    tick();
    chk("pre_rst_count", fifo_count, 1);
    tick();
    ctrl_en = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_count", fifo_count, 0);
    chk("mrst_empty", fifo_empty, 1);
    chk("mrst_perr", parity_err, 0);
    chk("mrst_par_en", rx_parity_en, 0);
    chk("mrst_irq", irq, 0);
    rx_done = 1'b1;
    rx_data = 8'hEE;
    tick();
    rx_done = 1'b0;
    tick();
    tick();
    chk("late_done_count", fifo_count, 0);
    chk("late_done_start", rx_start, 0);

    // Watchdog: rx_busy held high in RECEIVE
    ctrl_en = 1'b1;
    tick();
    tick();
    rx_busy = 1'b1;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    repeat (511) tick();
    chk("to_before", timeout, 0);
    tick();
    chk("to_set", timeout, 1);
    tick();
    chk("to_rearm", rx_start, 1);
    chk("to_fifo", fifo_count, 0);
    rx_busy = 1'b0;
`else
    repeat (600) tick();
    chk("no_to_flag", timeout, 0);
    chk("no_to_wait", rx_start, 0);
    chk("no_to_fifo", fifo_count, 0);
    rx_busy = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
